// File: rtl/data_selector_pkg.sv
// -----------------------------------------------------------------------------
// data_selector_pkg
// Shared definitions for the pipelined channel selector:
//   - default channel width / channel count, same as the original 2:1 selector
//     widened to four channels
//   - handshake/skid state encoding
//   - select-width helper (clog2 with a floor of 1)
// -----------------------------------------------------------------------------
package data_selector_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  // Occupancy of the two-entry output stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Number of select bits needed for n channels, never less than one
  function automatic int sel_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/data_selector_pipe_if.sv
// -----------------------------------------------------------------------------
// data_selector_pipe_if
// Bundles the upstream (in_*) and downstream (out_*) valid/ready channels of
// data_selector_pipe.
//   master : the environment side (drives in_data/in_sel/in_valid/out_ready)
//   slave  : the selector side   (drives in_ready/out_data/out_sel/out_valid)
// -----------------------------------------------------------------------------
interface data_selector_pipe_if
  import data_selector_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN
);

  localparam int SEL_W = sel_width(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/data_selector_comb.sv
// -----------------------------------------------------------------------------
// data_selector_comb
// Purely combinational NUM_IN:1 channel mux with range check.
//   in_data  : packed channels, channel k at [k*WIDTH +: WIDTH]
//   in_sel   : channel select
//   selected : chosen channel, all zeros when in_sel >= NUM_IN
//   oor      : 1 when in_sel does not name an existing channel
// -----------------------------------------------------------------------------
module data_selector_comb
  import data_selector_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN
) (
  input  logic [NUM_IN*WIDTH-1:0]     in_data,
  input  logic [sel_width(NUM_IN)-1:0] in_sel,
  output logic [WIDTH-1:0]            selected,
  output logic                        oor
);

  localparam int SEL_W = sel_width(NUM_IN);

  // Match the select against every real channel; no match means out of range,
  // which covers unused codes when NUM_IN is not a power of two.
  always_comb begin
    selected = '0;
    oor      = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        selected = in_data[k*WIDTH +: WIDTH];
        oor      = 1'b0;
      end else begin
        selected = selected;
        oor      = oor;
      end
    end
  end

endmodule

// File: rtl/data_selector_pipe.sv
// -----------------------------------------------------------------------------
// data_selector_pipe
// Registered NUM_IN:1 channel selector behind a valid/ready handshake with a
// two-entry (main + skid) output stage, sticky out-of-range flag and a
// wrapping transfer counter.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high
//   bus      : in_* / out_* handshake channels (slave side)
//   sel_err  : sticky, set when an out-of-range select is accepted
//   err_clr  : synchronous clear of sel_err (a simultaneous set wins)
//   xfer_cnt : completed output transfers, wraps
// -----------------------------------------------------------------------------
module data_selector_pipe
  import data_selector_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  data_selector_pipe_if.slave bus,
  output logic              sel_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int SEL_W = sel_width(NUM_IN);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] main_data;
  logic [SEL_W-1:0] main_sel;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] selected;
  logic             oor;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  data_selector_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_comb (
    .in_data  (bus.in_data),
    .in_sel   (bus.in_sel),
    .selected (selected),
    .oor      (oor)
  );

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data;
  assign bus.out_sel   = main_sel;

  // Next occupancy and which storage register loads this cycle
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end else begin
          state_nxt = EMPTY;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end else if (in_fire) begin
          // Downstream stalled: park the new word behind the current one
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end else begin
          state_nxt = ONE;
        end
      end
      TWO: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end else begin
          state_nxt = TWO;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Occupancy state plus handshake outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != TWO);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  // Main (output) and skid data/select registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= selected;
        main_sel  <= bus.in_sel;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end else begin
        main_data <= main_data;
        main_sel  <= main_sel;
      end
      if (load_skid) begin
        skid_data <= selected;
        skid_sel  <= bus.in_sel;
      end else begin
        skid_data <= skid_data;
        skid_sel  <= skid_sel;
      end
    end
  end

  // Sticky out-of-range flag; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (in_fire && oor) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_err;
    end
  end

  // Completed-transfer counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_cnt <= '0;
    end else if (out_fire) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end else begin
      xfer_cnt <= xfer_cnt;
    end
  end

endmodule

// File: doc/data_selector_pipe.md
Name: data_selector_pipe

Overview:
- Parametrised successor to the 32-bit 2:1 combinational DataSelector.
- Selects one of NUM_IN WIDTH-bit channels per transaction and registers the result behind a valid/ready handshake with a 2-entry skid buffer, so it can sit between CPU pipeline stages (e.g. the forwarding/writeback selection path) without adding combinational depth.
- Also flags out-of-range selects and counts completed transfers.

Parameters:
- WIDTH, 32, data width of each channel and of out_data.
- NUM_IN, 4, number of input channels (2..16; need not be a power of two).
- CNT_W, 16, width of the transfer counter.
- SEL_W (localparam), max(1, clog2(NUM_IN)), select width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel select for this transaction.
- in_valid  in  1  upstream offers a transaction.
- in_ready  out  1  block can accept; registered.
- out_data  out  WIDTH  selected data; registered.
- out_sel  out  SEL_W  select value that produced out_data.
- out_valid  out  1  out_data/out_sel valid.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  sticky: an out-of-range select was accepted.
- err_clr  in  1  synchronous clear of sel_err.
- xfer_cnt  out  CNT_W  count of completed output transfers.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-high, named clk and reset.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sel=0, sel_err=0, xfer_cnt=0, state=EMPTY, skid registers=0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Selection: selected = in_data channel in_sel if in_sel < NUM_IN, else all zeros. Selection is evaluated only on in_fire.
- Storage: main register (drives out_data/out_sel) and skid register, each holding data+sel.
- State machine:
  - EMPTY: on in_fire, main<=selected and go to ONE.
  - ONE, in_fire & out_fire: main<=selected, stay in ONE.
  - ONE, in_fire & !out_ready: skid<=selected, go to TWO.
  - ONE, !in_fire & out_fire: go to EMPTY.
  - ONE, otherwise: hold.
  - TWO: in_ready=0, so no accept. On out_fire, main<=skid and go to ONE; otherwise hold.
- Outputs from state: out_valid = (state != EMPTY); in_ready = (state != TWO), registered from next state.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Full throughput of 1 transfer/cycle while out_ready=1.
- Ordering: strict FIFO order; no drops, no duplicates.
- Output stability: while out_valid & !out_ready, out_data/out_sel must not change.
- Error flag: sel_err set on any in_fire with in_sel >= NUM_IN.
  - err_clr clears it.
  - Simultaneous set and clear: set wins.
  - The zero word is still transferred normally.
- Counter: xfer_cnt increments on each out_fire and wraps from 2^CNT_W-1 to 0 without saturating.
- Mid-operation reset: asserting reset discards buffered entries; all outputs return to reset values immediately (asynchronous). First accept is possible on the first clk edge after deassertion.

Decomposition:
- Package data_selector_pkg holds:
  - state enum {EMPTY, ONE, TWO};
  - sel-width helper function (clog2 with min 1);
  - default WIDTH/NUM_IN constants shared with the existing selector.
- One sub-module, data_selector_comb: purely combinational NUM_IN:1 mux with range check, outputs selected and oor.
- The handshake/skid logic, error flag and counter stay in the top.

Test Plan:
- Streaming: NUM_IN=4, channels 0xFFFF/0x5555/0xAAAA/0x1234, out_ready=1, in_sel 0,1,2,3 on consecutive cycles -> out_data 0xFFFF,0x5555,0xAAAA,0x1234 one cycle later, back to back; xfer_cnt=4.
- Backpressure: out_ready=0, two accepts (sel 1 then 3) -> in_ready=0 after the second; out_data holds 0x5555. Raise out_ready -> 0x5555 then 0x1234 delivered, then out_valid=0.
- Out-of-range: NUM_IN=3, in_sel=3 accepted -> out_data=0, sel_err=1 and stays set. err_clr pulsed alongside another bad select -> sel_err stays 1. err_clr alone -> 0.
- Simultaneous in/out in ONE: continuous in_valid with out_ready toggling 1/0 -> no loss, order preserved, in_ready never deasserts before TWO.
- Reset mid-operation: fill to TWO, assert reset between clock edges -> out_valid=0, in_ready=1, xfer_cnt=0 immediately. After release, a new transfer completes with 1-cycle latency.
- Counter wrap: CNT_W=4, 17 transfers -> xfer_cnt reads 15 then 0 then 1.
